// File: rtl/audio_pkg.sv
// Shared audio constants and receiver state encoding.
// Used by both the I2S capture and playback paths.
package audio_pkg;

    localparam int SAMPLE_W = 32;
    localparam int FRAME_W = 2 * SAMPLE_W;
    localparam logic LRCK_LEFT = 1'b0;

    typedef enum logic {
        HUNT,
        RUN
    } rx_state_t;

endpackage

// File: rtl/audio_fifo_sync.sv
// Single-clock show-ahead frame FIFO with a registered head word.
// The head register holds its last value while the FIFO is empty.
module audio_fifo_sync
    import audio_pkg::*;
#(
    parameter int WIDTH = FRAME_W,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   aclr_n,
    input  logic                   wrreq,
    input  logic [WIDTH-1:0]       data,
    input  logic                   rdreq,
    output logic [WIDTH-1:0]       q,
    output logic                   empty,
    output logic                   full,
    output logic [$clog2(DEPTH):0] usedw
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_nx;
    logic [CW-1:0]    cnt_nx;
    logic             do_rd;
    logic             do_wr;

    assign empty = (usedw == '0);
    assign full  = (usedw == CW'(DEPTH));

    always_comb begin
        do_rd  = rdreq && !empty;
        do_wr  = wrreq && (!full || do_rd);
        rd_nx  = rd_ptr + AW'(do_rd);
        cnt_nx = usedw + CW'(do_wr) - CW'(do_rd);
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= data;
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            usedw  <= '0;
            q      <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + AW'(1);
            rd_ptr <= rd_nx;
            usedw  <= cnt_nx;
            // A word written into the head slot is not in mem yet: bypass it.
            if (cnt_nx != '0) begin
                if (do_wr && (wr_ptr == rd_nx)) q <= data;
                else                            q <= mem[rd_nx];
            end
        end
    end

endmodule

// File: rtl/audio_in.sv
// I2S slave receiver: synchronises bck/lrck/din, deserialises stereo
// frames after frame alignment and buffers them in a show-ahead FIFO.
module audio_in
    import audio_pkg::*;
#(
    parameter int DATA_W     = SAMPLE_W,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                        clk,
    input  logic                        aclr_n,
    input  logic                        bck,
    input  logic                        lrck,
    input  logic                        din,
    input  logic                        rdreq,
    input  logic                        ovf_clr,
    output logic [2*DATA_W-1:0]         sample,
    output logic                        rdempty,
    output logic [$clog2(FIFO_DEPTH):0] rdusedw,
    output logic                        overflow,
    output logic                        locked
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    logic bck_s1, bck_s2, bck_d;
    logic lrck_s1, lrck_s2, lrck_s3;
    logic din_s1, din_s2, din_s3;
    logic rise_q;

    logic              ws_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] shift_nx;
    logic [DATA_W-1:0] left_word;
    logic              have_left;
    logic [2*DATA_W-1:0] frame;
    logic              push;
    logic              slot_end;
    logic              left_end;
    logic              right_end;
    logic              full;
    logic              drop;

    rx_state_t state_q, state_nx;

    // lrck/din get a third stage so they line up with the registered rise.
    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            bck_s1  <= 1'b0;
            bck_s2  <= 1'b0;
            bck_d   <= 1'b0;
            lrck_s1 <= 1'b0;
            lrck_s2 <= 1'b0;
            lrck_s3 <= 1'b0;
            din_s1  <= 1'b0;
            din_s2  <= 1'b0;
            din_s3  <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            bck_s1  <= bck;
            bck_s2  <= bck_s1;
            bck_d   <= bck_s2;
            lrck_s1 <= lrck;
            lrck_s2 <= lrck_s1;
            lrck_s3 <= lrck_s2;
            din_s1  <= din;
            din_s2  <= din_s1;
            din_s3  <= din_s2;
            rise_q  <= bck_s2 & ~bck_d;
        end
    end

    always_comb begin
        slot_end  = rise_q && (lrck_s3 != ws_d);
        left_end  = slot_end && (ws_d == LRCK_LEFT);
        right_end = slot_end && (ws_d != LRCK_LEFT);
        shift_nx  = shift;
        for (int i = 0; i < DATA_W; i++) begin
            if (rise_q && (bit_cnt == CNT_W'(DATA_W - 1 - i)))
                shift_nx[i] = din_s3;
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            ws_d      <= 1'b0;
            bit_cnt   <= '0;
            shift     <= '0;
            left_word <= '0;
            have_left <= 1'b0;
            frame     <= '0;
            push      <= 1'b0;
        end else begin
            push <= 1'b0;
            if (rise_q) begin
                ws_d <= lrck_s3;
                if (slot_end) begin
                    bit_cnt <= '0;
                    shift   <= '0;
                end else begin
                    shift <= shift_nx;
                    if (bit_cnt != CNT_W'(DATA_W))
                        bit_cnt <= bit_cnt + CNT_W'(1);
                end
            end
            if (left_end && state_q == RUN) begin
                left_word <= shift_nx;
                have_left <= 1'b1;
            end
            if (right_end && state_q == RUN && have_left) begin
                frame <= {left_word, shift_nx};
                push  <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) state_q <= HUNT;
        else         state_q <= state_nx;
    end

    always_comb begin
        state_nx = state_q;
        unique case (state_q)
            HUNT: if (right_end) state_nx = RUN;
            RUN:  state_nx = RUN;
        endcase
    end

    assign locked = (state_q == RUN);

    // A same-cycle pop frees the slot, so only an unpopped full push drops.
    assign drop = push & full & ~rdreq;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) overflow <= 1'b0;
        else         overflow <= drop | (overflow & ~ovf_clr);
    end

    audio_fifo_sync #(
        .WIDTH (2 * DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .aclr_n (aclr_n),
        .wrreq  (push),
        .data   (frame),
        .rdreq  (rdreq),
        .q      (sample),
        .empty  (rdempty),
        .full   (full),
        .usedw  (rdusedw)
    );

endmodule
